gf180mcu_osu_sc_gp12t3v3__oain1_pipe: RTL and testbench
=======================================================

GF180MCU_OSU_SC_GP12T3V3__OAIN1_PIPE -- requirements
Module: gf180mcu_osu_sc_gp12t3v3__oain1_pipe

Interface
REQ-001 SHALL have parameter N, default 3: A-input count per lane, legal 2..8.
REQ-002 SHALL have parameter W, default 1: lane count, legal 1..32.
REQ-003 SHALL have parameter STAGES, default 1: pipeline depth, legal 1..4.
REQ-004 SHALL have parameter MODE, default 0: 0 = OAI (inverted output), 1 = OA (non-inverted).
REQ-005 SHALL have port CLK, input, 1 bit: single clock, rising edge active.
REQ-006 SHALL have port RN, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port A, input, N*W bits: lane k, input i at bit i*W+k.
REQ-008 SHALL have port B, input, W bits: per-lane B term.
REQ-009 SHALL have port IN_VALID, input, 1 bit: A/B carry a valid operand.
REQ-010 SHALL have port IN_READY, output, 1 bit: block accepts the operand this cycle.
REQ-011 SHALL have port Y, output, W bits: registered result.
REQ-012 SHALL have port OUT_VALID, output, 1 bit: Y holds a valid result.
REQ-013 SHALL have port OUT_READY, input, 1 bit: consumer accepts Y this cycle.
REQ-014 SHALL have ports SE (input, 1), SI (input, 1), SO (output, 1): scan enable, scan in, scan out.

Function
REQ-015 SHALL compute per lane k: F = (A[0*W+k] | ... | A[(N-1)*W+k]) & B[k]; result = ~F when MODE=0, F when MODE=1.
REQ-016 SHALL contain STAGES stages; each stage holds W data bits and 1 valid bit.
REQ-017 SHALL accept an operand (transfer) on a rising CLK when IN_VALID=1 and IN_READY=1.
REQ-018 SHALL present a result STAGES cycles after acceptance when no stall occurs (latency = STAGES).
REQ-019 SHALL advance stage s when stage s+1 is empty or stage s+1 advances; the last stage advances when OUT_VALID=0 or OUT_READY=1.
REQ-020 SHALL drive IN_READY = (stage 0 empty) OR (stage 0 advances), combinationally; full throughput, one result per cycle, when OUT_READY is held high.
REQ-021 SHALL hold Y and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0; no data loss or duplication under any stall pattern.
REQ-022 SHALL load a bubble (valid=0, data unchanged) into stage 0 when it advances and IN_VALID=0.
REQ-023 SHALL, with all stages full and OUT_READY=0, drive IN_READY=0; simultaneous output pop and input push while full SHALL both complete in the same cycle.
REQ-024 SHALL, when SE=1, disable the functional handshake (IN_READY=0, stages do not advance) and shift all stage flops by one position per CLK: SI -> stage 0 valid -> stage 0 data[0..W-1] -> stage 1 valid -> ... -> last stage data[W-1] -> SO.
REQ-025 SHALL drive SO from the last scan flop at all times; OUT_VALID and Y reflect shifted contents.
REQ-026 SHALL resume normal operation the cycle after SE returns to 0, using the scanned-in state.

Reset
REQ-027 SHALL, while RN=0, asynchronously clear all valid and data flops: OUT_VALID=0, Y=0, SO=0, IN_READY=1 (if SE=0).
REQ-028 SHALL discard in-flight results on reset mid-operation; the first post-reset acceptance is the earliest rising CLK with RN=1.
REQ-029 SHALL, when RN deasserts, take the first functional action at the next rising CLK edge, with no partial-edge capture.

Structure
REQ-030 SHALL place the MODE encodings (OAI, OA) and parameter legal-range constants in the shared package gf180mcu_osu_sc_gp12t3v3_pkg.
REQ-031 SHALL use one sub-module, gf180mcu_osu_sc_gp12t3v3__oain1_stage (one stage: W data plus valid flops, scan mux, advance logic), instantiated STAGES times.
REQ-032 SHALL have a purely combinational lane function ahead of stage 0; there SHALL be no combinational path from A/B to Y.

Verification
REQ-033 N=3, W=1, STAGES=1, MODE=0: A=3'b000, B=1, IN_VALID=1, OUT_READY=1 -> next cycle Y=1, OUT_VALID=1; A=3'b010, B=1 -> Y=0; A=3'b111, B=0 -> Y=1.
REQ-034 W=4, STAGES=3, MODE=1: stream 8 back-to-back operands with OUT_READY=1 -> the first result appears 3 cycles after the first acceptance, then 8 consecutive valid results in order, each equal to the per-lane OA value.
REQ-035 STAGES=2: fill with 2 operands, OUT_READY=0 for 5 cycles -> IN_READY=0 and Y stable; OUT_READY=1 with IN_VALID=1 -> pop and push in the same cycle, in order.
REQ-036 STAGES=2, W=2: assert RN=0 mid-stream with 2 results in flight -> OUT_VALID=0, Y=2'b00 immediately; release -> the next accepted operand emerges after 2 cycles, with no stale result.
REQ-037 STAGES=1, W=2: SE=1, shift in 3'b101 (valid first) -> OUT_VALID=1, Y=2'b01 per the scan order; SO then outputs the prior contents; SE=0, OUT_READY=1 -> the scanned result pops in one cycle.
REQ-038 Randomized N, W, MODE with random IN_VALID/OUT_READY -> the scoreboard matches the REQ-015 model, with no loss, duplication or reordering.

Source files
------------

// File: rtl/gf180mcu_osu_sc_gp12t3v3_pkg.sv
// Shared definitions for the OAI-N1 pipelined cell family.
// Contents: MODE encodings (OAI = inverted output, OA = non-inverted) and
// the legal ranges of the N / W / STAGES parameters.
package gf180mcu_osu_sc_gp12t3v3_pkg;

    typedef enum int {
        MODE_OAI = 0,
        MODE_OA  = 1
    } mode_e;

    localparam int N_MIN      = 2;
    localparam int N_MAX      = 8;
    localparam int W_MIN      = 1;
    localparam int W_MAX      = 32;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if.sv
// Link between two pipeline positions: W data bits, valid/ready handshake
// and the scan-chain bit travelling in the same direction as the data.
//   master : drives valid, data, scan; reads ready
//   slave  : reads valid, data, scan; drives ready
interface gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if
    import gf180mcu_osu_sc_gp12t3v3_pkg::*;
#(
    parameter int W = 1
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         scan;

    modport master (output valid, output data, output scan, input ready);
    modport slave  (input valid, input data, input scan, output ready);
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__oain1_stage.sv
// One pipeline stage: W data flops plus a valid flop, with scan mux and
// advance logic.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset, clears valid and data
//   i_se    : scan enable; shifts the flops, suppresses the handshake
//   up      : upstream link (slave)  - operand in, ready out, scan in
//   dn      : downstream link (master) - result out, ready in, scan out
module gf180mcu_osu_sc_gp12t3v3__oain1_stage
    import gf180mcu_osu_sc_gp12t3v3_pkg::*;
#(
    parameter int W = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_se,
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if.slave  up,
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if.master dn
);
    logic         r_valid;
    logic [W-1:0] r_data;
    logic [W-1:0] w_shift;
    logic         w_adv;

    // The stage may load when it is empty or its content leaves this cycle.
    assign w_adv    = ~r_valid | dn.ready;
    assign up.ready = ~i_se & w_adv;

    assign dn.valid = r_valid;
    assign dn.data  = r_data;
    assign dn.scan  = r_data[W-1];

    // Scan order inside a stage: scan-in -> valid -> data[0] -> ... -> data[W-1].
    always_comb begin
        w_shift    = '0;
        w_shift[0] = r_valid;
        for (int unsigned k = 1; k < W; k++) begin
            w_shift[k] = r_data[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_se) begin
            r_valid <= up.scan;
            r_data  <= w_shift;
        end else if (w_adv) begin
            // A bubble clears valid but keeps the previous data.
            r_valid <= up.valid;
            if (up.valid) begin
                r_data <= up.data;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__oain1_pipe.sv
// Pipelined W-lane OR-AND(-invert) cell with valid/ready handshake and scan.
// Per lane k: F = (A[0*W+k] | ... | A[(N-1)*W+k]) & B[k]; Y = ~F (MODE=OAI)
// or F (MODE=OA), delivered STAGES cycles after acceptance.
//   CLK, RN             : clock (rising edge), async active-low reset
//   A[N*W], B[W]        : operand; lane k input i is A[i*W+k]
//   IN_VALID / IN_READY : input handshake (IN_READY combinational)
//   Y, OUT_VALID        : registered result and its valid flag
//   OUT_READY           : consumer accepts Y
//   SE, SI, SO          : scan enable / in / out over all stage flops
module gf180mcu_osu_sc_gp12t3v3__oain1_pipe
    import gf180mcu_osu_sc_gp12t3v3_pkg::*;
#(
    parameter int N      = 3,
    parameter int W      = 1,
    parameter int STAGES = 1,
    parameter int MODE   = 0
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic [N*W-1:0] A,
    input  logic [W-1:0]   B,
    input  logic           IN_VALID,
    output logic           IN_READY,
    output logic [W-1:0]   Y,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    input  logic           SE,
    input  logic           SI,
    output logic           SO
);
    logic [W-1:0] w_or;
    logic [W-1:0] w_lane;

    // A is lane-interleaved, so each W-wide slice is one input index
    // across all lanes and the OR reduces slice by slice.
    always_comb begin
        w_or = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_or = w_or | A[i*W +: W];
        end
    end

    assign w_lane = (MODE == int'(MODE_OA)) ? (w_or & B) : ~(w_or & B);

    // u_link[s] feeds stage s; u_link[STAGES] is the output side.
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if #(.W(W)) u_link [0:STAGES] ();

    assign u_link[0].valid = IN_VALID;
    assign u_link[0].data  = w_lane;
    assign u_link[0].scan  = SI;
    assign IN_READY        = u_link[0].ready;

    assign u_link[STAGES].ready = OUT_READY;
    assign OUT_VALID            = u_link[STAGES].valid;
    assign Y                    = u_link[STAGES].data;
    assign SO                   = u_link[STAGES].scan;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        gf180mcu_osu_sc_gp12t3v3__oain1_stage #(.W(W)) u_stage (
            .i_clk   (CLK),
            .i_rst_n (RN),
            .i_se    (SE),
            .up      (u_link[s]),
            .dn      (u_link[s+1])
        );
    end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__oain1_pipe.sv
// Self-checking bench for the pipelined OAI-N1 cell, four configurations:
//   d0: N=3 W=1 STAGES=1 OAI   d1: N=3 W=4 STAGES=3 OA
//   d2: N=2 W=2 STAGES=2 OAI   d3: N=4 W=2 STAGES=1 OAI
module tb_gf180mcu_osu_sc_gp12t3v3__oain1_pipe;

    logic clk = 1'b0;
    logic rn;
    logic se, si;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [2:0] a0; logic [0:0] b0; logic v0, r0;
    logic [11:0] a1; logic [3:0] b1; logic v1, r1;
    logic [3:0] a2; logic [1:0] b2; logic v2, r2;
    logic [7:0] a3; logic [1:0] b3; logic v3, r3;

    gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if #(.W(1)) o0 ();
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if #(.W(4)) o1 ();
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if #(.W(2)) o2 ();
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe_if #(.W(2)) o3 ();

    gf180mcu_osu_sc_gp12t3v3__oain1_pipe #(.N(3), .W(1), .STAGES(1), .MODE(0)) d0 (
        .CLK(clk), .RN(rn), .A(a0), .B(b0), .IN_VALID(v0), .IN_READY(r0),
        .Y(o0.data), .OUT_VALID(o0.valid), .OUT_READY(o0.ready),
        .SE(se), .SI(si), .SO(o0.scan));
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe #(.N(3), .W(4), .STAGES(3), .MODE(1)) d1 (
        .CLK(clk), .RN(rn), .A(a1), .B(b1), .IN_VALID(v1), .IN_READY(r1),
        .Y(o1.data), .OUT_VALID(o1.valid), .OUT_READY(o1.ready),
        .SE(se), .SI(si), .SO(o1.scan));
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe #(.N(2), .W(2), .STAGES(2), .MODE(0)) d2 (
        .CLK(clk), .RN(rn), .A(a2), .B(b2), .IN_VALID(v2), .IN_READY(r2),
        .Y(o2.data), .OUT_VALID(o2.valid), .OUT_READY(o2.ready),
        .SE(se), .SI(si), .SO(o2.scan));
    gf180mcu_osu_sc_gp12t3v3__oain1_pipe #(.N(4), .W(2), .STAGES(1), .MODE(0)) d3 (
        .CLK(clk), .RN(rn), .A(a3), .B(b3), .IN_VALID(v3), .IN_READY(r3),
        .Y(o3.data), .OUT_VALID(o3.valid), .OUT_READY(o3.ready),
        .SE(se), .SI(si), .SO(o3.scan));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference lane function, evaluated bit by bit.
    function automatic logic [31:0] model(input int n, input int w, input int mode,
                                          input logic [63:0] a, input logic [31:0] b);
        logic [31:0] y;
        y = '0;
        for (int k = 0; k < w; k++) begin
            logic f;
            f = 1'b0;
            for (int i = 0; i < n; i++) f = f | a[i*w+k];
            f = f & b[k];
            y[k] = (mode == 1) ? f : ~f;
        end
        return y;
    endfunction

    // d1 scoreboard
    logic [3:0] q [$];
    logic       stall_pend = 1'b0;
    logic [4:0] held;

    task automatic d1_cycle(input logic vin, input logic rdy);
        logic [31:0] e;
        @(negedge clk);
        if (stall_pend) chk("d1_stall_hold", {27'd0, o1.valid, o1.data}, {27'd0, held});
        a1 = 12'($urandom);
        b1 = 4'($urandom);
        v1 = vin;
        o1.ready = rdy;
        #1;
        if (o1.valid && o1.ready) begin
            if (q.size() == 0) chk("d1_sb_underflow", 32'd1, 32'd0);
            else chk("d1_sb_order", {28'd0, o1.data}, {28'd0, q.pop_front()});
        end
        if (v1 && r1) begin
            e = model(3, 4, 1, {52'd0, a1}, {28'd0, b1});
            q.push_back(e[3:0]);
        end
        stall_pend = o1.valid && !o1.ready;
        held = {o1.valid, o1.data};
    endtask

    typedef struct {
        logic [2:0] a;
        logic       b;
        logic       y;
    } vec0_t;

    vec0_t       tv [7];
    logic [11:0] sa [8];
    logic [3:0]  sb [8];
    logic        ev;
    logic        scan_in [3];
    logic        scan_so [3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{3'b000, 1'b1, 1'b1};
        tv[1] = '{3'b010, 1'b1, 1'b0};
        tv[2] = '{3'b111, 1'b0, 1'b1};
        tv[3] = '{3'b001, 1'b1, 1'b0};
        tv[4] = '{3'b100, 1'b1, 1'b0};
        tv[5] = '{3'b000, 1'b0, 1'b1};
        tv[6] = '{3'b110, 1'b1, 1'b0};
        sa = '{12'h000, 12'hFFF, 12'h001, 12'h010, 12'h100, 12'h8A5, 12'h3C0, 12'h00F};
        sb = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hF, 4'h6, 4'h9, 4'hA};
        scan_in = '{1'b0, 1'b1, 1'b1};
        scan_so = '{1'b0, 1'b1, 1'b0};

        se = 0; si = 0;
        a0 = '0; b0 = '0; v0 = 0; o0.ready = 1;
        a1 = '0; b1 = '0; v1 = 0; o1.ready = 1;
        a2 = '0; b2 = '0; v2 = 0; o2.ready = 1;
        a3 = '0; b3 = '0; v3 = 0; o3.ready = 1;
        rn = 1;
        #2 rn = 0;
        #2;
        chk("rst_d0_valid", {31'd0, o0.valid}, 0);
        chk("rst_d0_ready", {31'd0, r0}, 1);
        chk("rst_d1_y", {28'd0, o1.data}, 0);
        chk("rst_d1_valid", {31'd0, o1.valid}, 0);
        chk("rst_d2_so", {31'd0, o2.scan}, 0);
        chk("rst_d3_ready", {31'd0, r3}, 1);
        @(negedge clk);
        rn = 1;

        // d0: table of single-stage OAI vectors, back to back
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                chk("d0_y", {31'd0, o0.data}, {31'd0, tv[i-1].y});
                chk("d0_valid", {31'd0, o0.valid}, 1);
            end
            if (i < 7) begin
                a0 = tv[i].a; b0 = tv[i].b; v0 = 1;
                #1 chk("d0_in_ready", {31'd0, r0}, 1);
            end else begin
                v0 = 0;
            end
            @(negedge clk);
        end
        chk("d0_bubble_valid", {31'd0, o0.valid}, 0);
        chk("d0_bubble_data", {31'd0, o0.data}, {31'd0, tv[6].y});

        // d1: 8-operand stream, latency 3, full throughput
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                ev = (c >= 3 && c <= 10);
                chk("d1_lat_valid", {31'd0, o1.valid}, {31'd0, ev});
                if (ev) chk("d1_stream_y", {28'd0, o1.data}, model(3, 4, 1, {52'd0, sa[c-3]}, {28'd0, sb[c-3]}));
            end
            if (c < 8) begin a1 = sa[c]; b1 = sb[c]; v1 = 1; end
            else v1 = 0;
            #1;
            if (c < 8) chk("d1_in_ready", {31'd0, r1}, 1);
        end

        // d2: fill two stages, stall 5 cycles, then pop+push together
        @(negedge clk); o2.ready = 0; a2 = 4'b0001; b2 = 2'b11; v2 = 1;
        @(negedge clk); a2 = 4'b0000;
        @(negedge clk); a2 = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("d2_full_ready", {31'd0, r2}, 0);
            chk("d2_stall_valid", {31'd0, o2.valid}, 1);
            chk("d2_stall_y", {30'd0, o2.data}, 2'b10);
            @(negedge clk);
        end
        o2.ready = 1;
        #1 chk("d2_pop_push_ready", {31'd0, r2}, 1);
        @(negedge clk);
        chk("d2_after_pop_y", {30'd0, o2.data}, 2'b11);
        chk("d2_after_pop_valid", {31'd0, o2.valid}, 1);
        v2 = 0;
        @(negedge clk);
        chk("d2_pushed_y", {30'd0, o2.data}, 2'b01);
        chk("d2_pushed_valid", {31'd0, o2.valid}, 1);
        @(negedge clk);
        chk("d2_drained_valid", {31'd0, o2.valid}, 0);

        // d2: reset with two results in flight
        a2 = 4'b0000; b2 = 2'b11; v2 = 1;
        @(negedge clk); b2 = 2'b01;
        @(negedge clk); v2 = 0;
        #1 chk("d2_inflight_valid", {31'd0, o2.valid}, 1);
        rn = 0;
        #1;
        chk("d2_rst_valid", {31'd0, o2.valid}, 0);
        chk("d2_rst_y", {30'd0, o2.data}, 2'b00);
        chk("d2_rst_ready", {31'd0, r2}, 1);
        @(negedge clk);
        rn = 1; a2 = 4'b0001; b2 = 2'b11; v2 = 1;
        @(negedge clk);
        chk("d2_post_rst_lat1", {31'd0, o2.valid}, 0);
        v2 = 0;
        @(negedge clk);
        chk("d2_post_rst_valid", {31'd0, o2.valid}, 1);
        chk("d2_post_rst_y", {30'd0, o2.data}, 2'b10);
        @(negedge clk);
        chk("d2_no_stale", {31'd0, o2.valid}, 0);

        // d1: random handshake against the scoreboard, then drain
        for (int c = 0; c < 400; c++) d1_cycle(1'($urandom), 1'($urandom));
        for (int c = 0; c < 12; c++) d1_cycle(1'b0, 1'b1);
        chk("d1_drain_empty", q.size(), 0);

        // d3: scan shift through a held result, then pop the scanned state
        @(negedge clk); o3.ready = 0; a3 = 8'h01; b3 = 2'b11; v3 = 1;
        @(negedge clk); v3 = 0;
        #1;
        chk("d3_pre_scan_y", {30'd0, o3.data}, 2'b10);
        chk("d3_pre_scan_so", {31'd0, o3.scan}, 1);
        se = 1; a3 = 8'hFF; b3 = 2'b11; v3 = 1; o3.ready = 1;
        for (int i = 0; i < 3; i++) begin
            si = scan_in[i];
            #1 chk("d3_scan_ready", {31'd0, r3}, 0);
            @(negedge clk);
            chk("d3_scan_so", {31'd0, o3.scan}, {31'd0, scan_so[i]});
        end
        chk("d3_scan_valid", {31'd0, o3.valid}, 1);
        chk("d3_scan_y", {30'd0, o3.data}, 2'b01);
        se = 0; v3 = 0;
        #1 chk("d3_resume_ready", {31'd0, r3}, 1);
        @(negedge clk);
        chk("d3_popped_valid", {31'd0, o3.valid}, 0);
        chk("d3_popped_data", {30'd0, o3.data}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
